// File: rtl/dilated_tap_pkg.sv
// Shared sizing helpers and sample type for the dilated tap buffer.
package dilated_tap_pkg;

    localparam int unsigned SampleW = 16;

    typedef logic signed [SampleW-1:0] sample_t;

    // Storage slots per channel needed to reach the oldest dilated tap.
    function automatic int unsigned tap_len(input int unsigned k, input int unsigned d);
        return (k - 1) * d + 1;
    endfunction

    function automatic int unsigned fill_w(input int unsigned l);
        return $clog2(l + 1);
    endfunction

endpackage

// File: rtl/dilated_tap_buffer_shift_lane.sv
// One channel's L-slot delay line; slot 0 is the oldest, slot L-1 the newest.
module shift_lane #(
    parameter int unsigned W = 16,
    parameter int unsigned L = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           shift_i,
    input  logic           clear_i,
    input  logic [W-1:0]   din_i,
    output logic [L*W-1:0] slots_o
);

    logic [L*W-1:0] slots_q, slots_d;

    always_comb begin
        slots_d = slots_q;
        if (clear_i) begin
            slots_d = '0;
        end else if (shift_i) begin
            for (int i = 0; i < int'(L) - 1; i++) begin
                slots_d[i*W +: W] = slots_q[(i+1)*W +: W];
            end
            slots_d[(L-1)*W +: W] = din_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign slots_o = slots_q;

endmodule

// File: rtl/dilated_tap_buffer.sv
// Multi-channel dilated tap delay line with fill tracking.
// Optional macro DILATED_TAP_BUFFER_PAD_VALID_EN treats reset zeros as causal padding.
module dilated_tap_buffer
    import dilated_tap_pkg::*;
#(
    parameter int unsigned W = 16,
    parameter int unsigned C = 1,
    parameter int unsigned K = 4,
    parameter int unsigned D = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    input  logic [C*W-1:0]                        inp,
    input  logic                                  clear,
    output logic [K*C*W-1:0]                      out_taps,
    output logic                                  out_valid,
    output logic                                  full,
    output logic [fill_w(tap_len(K, D))-1:0]      fill_count
);

    localparam int unsigned L  = tap_len(K, D);
    localparam int unsigned FW = fill_w(L);

    logic [L*W-1:0] lane_slots [C];
    logic [FW-1:0]  fill_q, fill_d;
    logic           valid_q, valid_d;
    logic           accept;

    assign accept = in_valid && !clear;

    for (genvar c = 0; c < int'(C); c++) begin : g_lane
        shift_lane #(
            .W(W),
            .L(L)
        ) u_lane (
            .clk_i  (clk),
            .rst_i  (rst),
            .shift_i(in_valid),
            .clear_i(clear),
            .din_i  (inp[c*W +: W]),
            .slots_o(lane_slots[c])
        );
    end

    // Tap k sits at slot k*D, so the newest tap is always the last slot.
    for (genvar k = 0; k < int'(K); k++) begin : g_tap
        for (genvar c = 0; c < int'(C); c++) begin : g_ch
            assign out_taps[(k*C+c)*W +: W] = lane_slots[c][k*D*W +: W];
        end
    end

    always_comb begin
        fill_d  = fill_q;
        valid_d = 1'b0;
        if (clear) begin
            fill_d = '0;
        end else if (in_valid) begin
            if (fill_q != FW'(L)) begin
                fill_d = fill_q + FW'(1);
            end
`ifdef DILATED_TAP_BUFFER_PAD_VALID_EN
            valid_d = 1'b1;
`else
            valid_d = (fill_d == FW'(L));
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fill_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            fill_q  <= fill_d;
            valid_q <= valid_d && accept;
        end
    end

    assign out_valid  = valid_q;
    assign fill_count = fill_q;
`ifdef DILATED_TAP_BUFFER_PAD_VALID_EN
    assign full = 1'b1;
`else
    assign full = (fill_q == FW'(L));
`endif

endmodule

// File: doc/dilated_tap_buffer.md
Name: dilated_tap_buffer

Overview:
- Multi-channel, parametrised left-shift delay line feeding one dilated causal convolution layer.
- Keeps the last (K-1)*D+1 samples per channel and exposes K taps spaced D samples apart, oldest first.
- Shifts only on accepted input samples, tracks fill level, and flags when the window holds real data rather than reset zeros.
- Sits between the previous layer's activation stream and the layer's MAC array.

Parameters:
- W, 16, signed bit width of one sample
- C, 1, number of independent channels shifted in lockstep
- K, 4, number of taps presented (kernel size)
- D, 1, dilation; tap spacing in samples, D >= 1

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  sample strobe; shift occurs only when high
- inp  input  C*W  signed samples; channel c at bits [c*W +: W]
- clear  input  1  synchronous flush of contents and fill count
- out_taps  output  K*C*W  tap k of channel c at bits [(k*C+c)*W +: W]; k=0 oldest, k=K-1 newest
- out_valid  output  1  one-cycle pulse: window updated and full
- full  output  1  level: fill count has reached L
- fill_count  output  $clog2(L+1)  samples held, saturating at L

Behaviour:
- Interface: single clock clk; reset rst is asynchronous, active-high.
- L = (K-1)*D+1 storage slots per channel, index 0 oldest to L-1 newest.
- Tap k = slot k*D, so tap K-1 is always slot L-1, the newest sample.
- Reset, asserted at any time including mid-stream:
  - all slots 0
  - out_taps 0, out_valid 0, full 0, fill_count 0
- No initial-block reliance; reset defines state.
- Accepted sample (in_valid=1, clear=0) at edge n:
  - slot i <= slot i+1 for i < L-1; slot L-1 <= inp; all channels together.
  - fill_count <= min(fill_count+1, L).
- in_valid=0: storage, taps and fill_count hold; out_valid 0.
- Latency: sample accepted at edge n appears on tap K-1 after edge n. out_taps are direct register outputs with no combinational path from inp.
- out_valid is registered. It is 1 in the cycle after an accepted sample if the post-update fill_count equals L, otherwise 0.
- full = (fill_count == L); registered or derived from the registered count.
- fill_count saturates at L and never wraps; further samples keep shifting and keep pulsing out_valid.
- clear=1 at an edge:
  - all slots 0, fill_count 0, out_valid 0.
  - clear wins over a simultaneous in_valid; that sample is discarded.
- Signed values are stored bit-exact; no arithmetic or saturation on data.
- K=1 degenerates to a single register (L=1), full after the first sample.
- D=1 with K=4, C=1 reproduces the existing 4-deep left shift buffer data path.

Optional Feature:
- Macro: DILATED_TAP_BUFFER_PAD_VALID_EN
- Defined: zeros from reset or clear count as causal padding.
  - out_valid pulses the cycle after every accepted sample, regardless of fill.
  - full is tied to 1.
  - fill_count is still maintained.
- Undefined: out_valid and full behave as specified above.

Decomposition:
- Package dilated_tap_pkg holds:
  - function tap_len(K, D) returning L
  - function fill_w(L) returning $clog2(L+1)
  - parametrised typedef sample_t, logic signed [W-1:0]
- Sub-module shift_lane: one channel's L-slot delay line with shift enable and clear, exposing all slots.
  - Instantiated C times via generate.
  - Tap selection and the fill counter stay in the top module.

Test Plan (W=16, C=2, K=4, D=2, L=7 unless noted):
- Reset then idle: out_taps all 0, out_valid 0, full 0, fill_count 0 for 10 cycles with in_valid=0.
- Fill: feed ch0 = 1..7 and ch1 = -1..-7 on consecutive cycles.
  - fill_count steps 1..7; out_valid first pulses after the 7th sample.
  - Then ch0 taps = 1,3,5,7 and ch1 taps = -1,-3,-5,-7.
- Steady state with gaps: feed 8, idle 3 cycles, feed 9.
  - Taps hold 2,4,6,8 through the gap; out_valid pulses only after 8 and after 9.
  - After 9, taps = 3,5,7,9; fill_count stays 7.
- Clear collision: assert clear together with in_valid (sample 100).
  - Next cycle all taps 0, fill_count 0, out_valid 0.
  - 100 appears nowhere.
- Async reset mid-stream: pulse rst between edges after 5 samples.
  - Outputs go to 0 immediately, without waiting for a clk edge.
  - The next 7 samples are needed before out_valid.
- Legacy config (C=1, K=4, D=1), inputs 0x7FFF, 0x8000, 3, 4: taps = 32767, -32768, 3, 4.
  - With DILATED_TAP_BUFFER_PAD_VALID_EN, out_valid pulses after every sample from the first.
